alu_scan_pipe: RTL and testbench

Parametrised successor to the 4-bit scan ALU. A two-stage pipelined WIDTH-bit ALU with valid/ready handshake, registered result and flags (C, Z, N, V), and one full scan chain through every flop. Sits between the operand source and the result consumer as a testable datapath slice.

---
 rtl/alu_scan_pipe.sv | 147 ++++++++++++++
 tb/tb_alu_scan_pipe.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_scan_pipe.sv
// Two-stage pipelined WIDTH-bit ALU with valid/ready handshake and one full scan chain.
// Define ALU_SCAN_EXT_OPS_EN to enable ops 100-111 (XOR, SHL, SHR, CMP); otherwise they yield 0 / flags 0010.
module alu_scan_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scan_en,
  input  logic             scan_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op_code,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             scan_out
);

  localparam int SH = $clog2(WIDTH);
  localparam int L  = 3*WIDTH + 9;
  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [2:0]       s1_op_q, s1_op_d;
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic             s2_valid_q, s2_valid_d;

  logic             adv1, adv2;
  logic [L-1:0]     chain;

  logic [WIDTH:0]   add_full, sub_full;
  logic             add_v, sub_v;
  logic [WIDTH-1:0] alu_res;
  logic [3:0]       alu_flags;
  logic             alu_c, alu_v, alu_z, alu_n;
`ifdef ALU_SCAN_EXT_OPS_EN
  logic [SH-1:0]    shamt;
  logic [WIDTH:0]   shl_ext, shr_ext;
`endif

  assign adv2      = !s2_valid_q || out_ready;
  assign adv1      = !s1_valid_q || adv2;
  assign in_ready  = adv1 && !scan_en;
  assign out_valid = s2_valid_q && !scan_en;
  assign result    = result_q;
  assign flags     = flags_q;

  assign chain    = {s2_valid_q, flags_q, result_q, s1_valid_q, s1_op_q, s1_b_q, s1_a_q};
  assign scan_out = chain[L-1];

  // Stage 2 combinational ALU, fed only from the stage 1 registers
  always_comb begin
    add_full = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    sub_full = {1'b0, s1_a_q} + {1'b0, ~s1_b_q} + ONE;
    add_v    = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) && (add_full[WIDTH-1] != s1_a_q[WIDTH-1]);
    sub_v    = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) && (sub_full[WIDTH-1] != s1_a_q[WIDTH-1]);
`ifdef ALU_SCAN_EXT_OPS_EN
    shamt   = s1_b_q[SH-1:0];
    // One guard bit catches the last bit shifted out; it is 0 for a zero shift
    shl_ext = {1'b0, s1_a_q} << shamt;
    shr_ext = {s1_a_q, 1'b0} >> shamt;
`endif
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (s1_op_q)
      3'b000: begin alu_res = add_full[WIDTH-1:0]; alu_c = add_full[WIDTH]; alu_v = add_v; end
      3'b001: begin alu_res = sub_full[WIDTH-1:0]; alu_c = sub_full[WIDTH]; alu_v = sub_v; end
      3'b010: alu_res = s1_a_q & s1_b_q;
      3'b011: alu_res = s1_a_q | s1_b_q;
`ifdef ALU_SCAN_EXT_OPS_EN
      3'b100: alu_res = s1_a_q ^ s1_b_q;
      3'b101: begin alu_res = shl_ext[WIDTH-1:0]; alu_c = shl_ext[WIDTH]; end
      3'b110: begin alu_res = shr_ext[WIDTH:1];   alu_c = shr_ext[0];     end
      3'b111: begin alu_res = s1_a_q; alu_c = sub_full[WIDTH]; alu_v = sub_v; end
`endif
      default: alu_res = '0;
    endcase
    alu_z = (alu_res == '0);
    alu_n = alu_res[WIDTH-1];
`ifdef ALU_SCAN_EXT_OPS_EN
    if (s1_op_q == 3'b111) begin
      alu_z = (s1_a_q == s1_b_q);
      alu_n = sub_full[WIDTH-1];
    end
`endif
    alu_flags = {alu_v, alu_n, alu_z, alu_c};
  end

  always_comb begin
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    s1_valid_d = s1_valid_q;
    result_d   = result_q;
    flags_d    = flags_q;
    s2_valid_d = s2_valid_q;
    if (scan_en) begin
      {s2_valid_d, flags_d, result_d, s1_valid_d, s1_op_d, s1_b_d, s1_a_d} = {chain[L-2:0], scan_in};
    end else begin
      if (adv2) begin
        s2_valid_d = s1_valid_q;
        if (s1_valid_q) begin
          result_d = alu_res;
          flags_d  = alu_flags;
        end
      end
      if (adv1) begin
        if (in_valid) begin
          s1_a_d     = a;
          s1_b_d     = b;
          s1_op_d    = op_code;
          s1_valid_d = 1'b1;
        end else begin
          s1_valid_d = 1'b0;
        end
      end
    end
  end

  // Stage 1 / stage 2 register boundary; every flop is on the scan chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= '0;
      s1_valid_q <= 1'b0;
      result_q   <= '0;
      flags_q    <= '0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_op_q    <= s1_op_d;
      s1_valid_q <= s1_valid_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
      s2_valid_q <= s2_valid_d;
    end
  end

endmodule

// File: tb/tb_alu_scan_pipe.sv
// Directed bench for alu_scan_pipe (WIDTH=8) with a result/flags scoreboard and scan-chain checks.
module tb_alu_scan_pipe;

  localparam int W = 8;

  logic         clk, rst, scan_en, scan_in, in_valid, in_ready;
  logic [2:0]   op_code;
  logic [W-1:0] a, b, result;
  logic         out_valid, out_ready, scan_out;
  logic [3:0]   flags;

  alu_scan_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .scan_en(scan_en), .scan_in(scan_in),
    .in_valid(in_valid), .in_ready(in_ready), .op_code(op_code),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags), .scan_out(scan_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [11:0] sbq[$];
  logic        acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: returns {V,N,Z,C, result}
  function automatic logic [11:0] model(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
    int ua, ub, sa, sb, r, amt;
    bit c, v, z, n;
    ua = x; ub = y; sa = $signed(x); sb = $signed(y);
    r = 0; c = 0; v = 0; amt = ub % 8;
    case (op)
      3'd0: begin r = ua + ub; c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); r = r & 255; end
      3'd1: begin r = (ua - ub) & 255; c = (ua >= ub); v = (sa - sb > 127) || (sa - sb < -128); end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
`ifdef ALU_SCAN_EXT_OPS_EN
      3'd4: r = ua ^ ub;
      3'd5: begin r = (ua << amt) & 255; c = (amt != 0) && (((ua >> (8 - amt)) & 1) == 1); end
      3'd6: begin r = ua >> amt; c = (amt != 0) && (((ua >> (amt - 1)) & 1) == 1); end
      3'd7: begin r = ua; c = (ua >= ub); v = (sa - sb > 127) || (sa - sb < -128); end
`endif
      default: r = 0;
    endcase
    z = (r == 0);
    n = (r > 127);
`ifdef ALU_SCAN_EXT_OPS_EN
    if (op == 3'd7) begin
      z = (ua == ub);
      n = (((ua - ub) & 255) > 127);
    end
`endif
    return {v, n, z, c, r[7:0]};
  endfunction

  // Called at a falling edge with inputs already driven; samples, then advances one clock.
  task automatic cycle();
    logic [11:0] e;
    #1;
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) chk("unexpected_beat", {52'd0, flags, result}, 64'd0);
      else begin
        e = sbq.pop_front();
        chk("result", result, e[7:0]);
        chk("flags", flags, e[11:8]);
      end
    end
    if (acc) sbq.push_back(model(op_code, a, b));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
    int n;
    op_code = op; a = x; b = y; in_valid = 1'b1; n = 0;
    do begin
      cycle();
      n++;
    end while (!acc && n < 50);
    in_valid = 1'b0;
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  task automatic flush(input int n);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (n) cycle();
    chk("sb_empty", sbq.size(), 0);
  endtask

  task automatic scan_step(input logic si, output logic so);
    scan_en = 1'b1; scan_in = si;
    #1 so = scan_out;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [32:0] pat, got, cap_exp, inj;
  logic        so;
  logic [11:0] e;
  int          ok, stale;

  initial begin
    rst = 1'b1; scan_en = 1'b0; scan_in = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op_code = '0; a = '0; b = '0; acc = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", flags, 0);
    chk("rst_scan_out", scan_out, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);

    // Latency: result appears after the accept edge plus one more edge
    out_ready = 1'b1;
    send(3'd0, 8'hF0, 8'h20);
    #1 chk("lat_e1_out_valid", out_valid, 0);
    cycle();
    #1 chk("lat_e2_out_valid", out_valid, 1);
    chk("lat_e2_result", result, 8'h10);
    cycle();
    flush(3);

    send(3'd1, 8'h05, 8'h07);
    send(3'd1, 8'h80, 8'h01);
    flush(4);

    // Backpressure: three beats with the consumer stalled
    out_ready = 1'b0;
    send(3'd0, 8'd1, 8'd1);
    send(3'd0, 8'd2, 8'd2);
    op_code = 3'd0; a = 8'd3; b = 8'd3; in_valid = 1'b1;
    #1;
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_result", result, 8'h02);
    cycle();
    chk("bp_not_accepted", acc, 0);
    #1 chk("bp_result_hold", result, 8'h02);
    out_ready = 1'b1;
    send(3'd0, 8'd3, 8'd3);
    flush(4);
    #1 chk("bp_drained", out_valid, 0);

    // Throughput: one accept per cycle with the consumer ready
    ok = 0; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      op_code = 3'(i % 2); a = 8'($urandom); b = 8'($urandom);
      cycle();
      if (acc) ok++;
    end
    chk("throughput", ok, 6);
    flush(4);

    // Every op code, including the macro-dependent ones
    send(3'd5, 8'h81, 8'h01);
    send(3'd6, 8'h81, 8'h01);
    send(3'd5, 8'h81, 8'h00);
    send(3'd4, 8'hA5, 8'hA5);
    send(3'd7, 8'h33, 8'h33);
    send(3'd7, 8'h10, 8'h20);
    send(3'd2, 8'hF0, 8'h0F);
    send(3'd3, 8'h80, 8'h01);
    send(3'd0, 8'h7F, 8'h01);
    send(3'd6, 8'h80, 8'h07);
    flush(4);

    // Random handshake traffic
    for (int i = 0; i < 60; i++) begin
      in_valid = 1'($urandom); op_code = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    flush(4);

    // Scan shift-through
    pat = 33'h1_5A5A_A5A5;
    in_valid = 1'b0;
    for (int i = 0; i < 33; i++) begin
      scan_step(pat[32-i], so);
      if (i == 0) begin
        #1;
        chk("scan_in_ready", in_ready, 0);
        chk("scan_out_valid", out_valid, 0);
      end
    end
    for (int i = 0; i < 33; i++) begin
      scan_step(1'b0, so);
      got[32-i] = so;
    end
    chk("scan_pattern", got, pat);
    scan_en = 1'b0;

    // Functional capture, then unload
    out_ready = 1'b0;
    send(3'd0, 8'h0F, 8'h01);
    cycle();
    #1;
    chk("cap_out_valid", out_valid, 1);
    e = sbq.pop_front();
    chk("cap_result", result, e[7:0]);
    cap_exp = {1'b1, 4'b0000, 8'h10, 1'b0, 3'b000, 8'h01, 8'h0F};
    for (int i = 0; i < 33; i++) begin
      scan_step(1'b0, so);
      got[32-i] = so;
    end
    chk("cap_unload", got, cap_exp);

    // Resume from an injected chain state holding a valid result beat
    inj = {1'b1, 4'b0101, 8'h55, 1'b0, 3'b000, 8'h00, 8'h00};
    for (int i = 0; i < 33; i++) scan_step(inj[32-i], so);
    scan_en = 1'b0;
    sbq.push_back({4'b0101, 8'h55});
    #1 chk("inj_out_valid", out_valid, 1);
    flush(3);

    // Asynchronous reset with two beats in flight
    out_ready = 1'b0;
    send(3'd0, 8'h11, 8'h22);
    send(3'd0, 8'h33, 8'h44);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_flags", flags, 0);
    sbq.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    stale = 0;
    repeat (6) begin
      #1 if (out_valid) stale++;
      @(posedge clk);
      @(negedge clk);
    end
    chk("mid_rst_no_stale", stale, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
